// File: rtl/reg_file_pkg.sv
// Shared defaults and width helper for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefNumRegs    = 32;
  localparam int unsigned DefNumWrPorts = 2;
  localparam int unsigned DefNumRdPorts = 2;

  // A single-register file still needs a 1-bit address bus.
  function automatic int unsigned addr_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/reg_file_wr_sel.sv
// Per-register write-port select: the highest enabled port index targeting a
// register wins; out-of-range addresses never match any register.
module reg_file_wr_sel
  import reg_file_pkg::*;
#(
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned NumRegs    = DefNumRegs,
  parameter int unsigned NumWrPorts = DefNumWrPorts,
  parameter int unsigned AddrWidth  = addr_width(NumRegs)
) (
  input  logic [NumWrPorts-1:0]                wr_en_i,
  input  logic [NumWrPorts-1:0][AddrWidth-1:0] wr_addr_i,
  input  logic [NumWrPorts-1:0][DataWidth-1:0] wr_data_i,
  output logic [NumRegs-1:0]                   reg_we_o,
  output logic [NumRegs-1:0][DataWidth-1:0]    reg_wdata_o
);

  always_comb begin
    reg_we_o    = '0;
    reg_wdata_o = '0;
    for (int r = 0; r < int'(NumRegs); r++) begin
      // Ascending scan so a later (higher) port overrides earlier ones.
      for (int p = 0; p < int'(NumWrPorts); p++) begin
        if (wr_en_i[p] && (wr_addr_i[p] == AddrWidth'(r))) begin
          reg_we_o[r]    = 1'b1;
          reg_wdata_o[r] = wr_data_i[p];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_nwmr.sv
// N-write / M-read register file with registered read ports and bulk clear.
// Define REG_FILE_NWMR_BYPASS_EN for write-first reads (clear and writes bypass to read ports).
module reg_file_nwmr
  import reg_file_pkg::*;
#(
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned NumRegs      = DefNumRegs,
  parameter int unsigned NumWrPorts   = DefNumWrPorts,
  parameter int unsigned NumRdPorts   = DefNumRdPorts,
  parameter int unsigned NumRegsWidth = addr_width(NumRegs)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clr_i,
  input  logic [NumWrPorts-1:0]                   wr_en_i,
  input  logic [NumWrPorts-1:0][NumRegsWidth-1:0] wr_addr_i,
  input  logic [NumWrPorts-1:0][DataWidth-1:0]    wr_data_i,
  input  logic [NumRdPorts-1:0]                   rd_en_i,
  input  logic [NumRdPorts-1:0][NumRegsWidth-1:0] rd_addr_i,
  output logic [NumRdPorts-1:0][DataWidth-1:0]    rd_data_o,
  output logic [NumRdPorts-1:0]                   rd_valid_o
);

  logic [NumRegs-1:0][DataWidth-1:0]    regs_q, regs_d;
  logic [NumRegs-1:0]                   reg_we;
  logic [NumRegs-1:0][DataWidth-1:0]    reg_wdata;
  logic [NumRdPorts-1:0][DataWidth-1:0] rd_data_q, rd_data_d;
  logic [NumRdPorts-1:0]                rd_valid_q, rd_valid_d;

  reg_file_wr_sel #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .NumWrPorts(NumWrPorts),
    .AddrWidth (NumRegsWidth)
  ) u_wr_sel (
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .reg_we_o   (reg_we),
    .reg_wdata_o(reg_wdata)
  );

  always_comb begin
    regs_d = regs_q;
    if (clr_i) begin
      regs_d = '0;
    end else begin
      for (int r = 0; r < int'(NumRegs); r++) begin
        if (reg_we[r]) regs_d[r] = reg_wdata[r];
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int q = 0; q < int'(NumRdPorts); q++) begin
      if (rd_en_i[q]) begin
        rd_valid_d[q] = 1'b1;
        rd_data_d[q]  = '0;
        if (32'(rd_addr_i[q]) < NumRegs) begin
`ifdef REG_FILE_NWMR_BYPASS_EN
          if (clr_i) begin
            rd_data_d[q] = '0;
          end else if (reg_we[rd_addr_i[q]]) begin
            rd_data_d[q] = reg_wdata[rd_addr_i[q]];
          end else begin
            rd_data_d[q] = regs_q[rd_addr_i[q]];
          end
`else
          rd_data_d[q] = regs_q[rd_addr_i[q]];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_reg_file_nwmr.sv
// Scoreboard bench for reg_file_nwmr (20 registers, 2 write / 2 read ports).
module tb_reg_file_nwmr;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 20;
  localparam int unsigned AW = 5;
`ifdef REG_FILE_NWMR_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   clr_i = 1'b0;
  logic [1:0]             wr_en_i = '0;
  logic [1:0][AW-1:0]     wr_addr_i = '0;
  logic [1:0][DW-1:0]     wr_data_i = '0;
  logic [1:0]             rd_en_i = '0;
  logic [1:0][AW-1:0]     rd_addr_i = '0;
  logic [1:0][DW-1:0]     rd_data_o;
  logic [1:0]             rd_valid_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q [2][$];

  reg_file_nwmr #(
    .DataWidth (DW),
    .NumRegs   (NR),
    .NumWrPorts(2),
    .NumRdPorts(2)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every presented read response is matched against the scoreboard.
  always @(negedge clk_i) begin
    for (int q = 0; q < 2; q++) begin
      if (rd_valid_o[q]) begin
        n_checks++;
        if (exp_q[q].size() == 0) begin
          $display("FAIL rd%0d_unexpected: got valid data %h, required no response", q, rd_data_o[q]);
        end else begin
          logic [DW-1:0] e;
          e = exp_q[q].pop_front();
          if (rd_data_o[q] === e) n_pass++;
          else $display("FAIL rd%0d_data: got %h, required %h", q, rd_data_o[q], e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en_i[p]   = 1'b1;
    wr_addr_i[p] = AW'(a);
    wr_data_i[p] = d;
  endtask

  task automatic rd(input int q, input int a, input logic [DW-1:0] e);
    rd_en_i[q]   = 1'b1;
    rd_addr_i[q] = AW'(a);
    exp_q[q].push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    wr_en_i = '0;
    rd_en_i = '0;
    clr_i   = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_valid", 64'(rd_valid_o), 64'd0);
    check("reset_data", 64'(rd_data_o), 64'd0);
    #10 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Every address on every port reads 0 after reset, out-of-range included
    for (int a = 0; a < 32; a++) begin
      rd(0, a, 32'h0);
      rd(1, 31 - a, 32'h0);
      tick();
    end

    // Same-address collision: port 1 wins; distinct addresses both land
    wr(0, 5, 32'hAAAA_0001);
    wr(1, 5, 32'h5555_0002);
    tick();
    rd(0, 5, 32'h5555_0002);
    rd(1, 5, 32'h5555_0002);
    tick();
    wr(0, 6, 32'h0000_0066);
    wr(1, 7, 32'h0000_0077);
    tick();
    rd(0, 6, 32'h0000_0066);
    rd(1, 7, 32'h0000_0077);
    tick();

    // Read/write same cycle
    wr(0, 3, 32'h1234_5678);
    rd(0, 3, Bypass ? 32'h1234_5678 : 32'h0);
    tick();
    rd(0, 3, 32'h1234_5678);
    rd(1, 3, 32'h1234_5678);
    tick();
    wr(0, 8, 32'h0000_0011);
    wr(1, 8, 32'h0000_0022);
    rd(1, 8, Bypass ? 32'h0000_0022 : 32'h0);
    tick();

    // Fill with index (writes above 19 are dropped), then clear against a write
    for (int i = 0; i < 32; i++) begin
      wr(0, i, DW'(i));
      tick();
    end
    rd(0, 7, 32'd7);
    rd(1, 19, 32'd19);
    tick();
    rd(0, 25, 32'h0);
    rd(1, 0, 32'h0);
    tick();
    clr_i = 1'b1;
    wr(1, 7, 32'hFFFF_FFFF);
    rd(0, 7, Bypass ? 32'h0 : 32'd7);
    tick();
    for (int i = 0; i < 20; i++) begin
      rd(0, i, 32'h0);
      rd(1, 19 - i, 32'h0);
      tick();
    end

    // Out-of-range write must not alias onto any in-range register
    wr(0, 4, 32'h0000_0044);
    tick();
    wr(0, 25, 32'hDEAD_BEEF);
    tick();
    rd(0, 25, 32'h0);
    rd(1, 4, 32'h0000_0044);
    tick();
    rd(0, 5, 32'h0);
    rd(1, 9, 32'h0);
    tick();

    // Reset while a read is pending
    wr(0, 3, 32'hCAFE_0003);
    tick();
    rd(0, 3, 32'hCAFE_0003);
    rd(1, 4, 32'h0000_0044);
    tick();
    @(negedge clk_i);
    #1;
    rd_en_i   = 2'b11;
    rd_addr_i = {AW'(4), AW'(3)};
    #1 rst_ni = 1'b0;
    #1;
    check("midreset_valid", 64'(rd_valid_o), 64'd0);
    check("midreset_data", 64'(rd_data_o), 64'd0);
    rd_en_i = '0;
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    rd(0, 3, 32'h0);
    rd(1, 4, 32'h0);
    tick();

    @(negedge clk_i);
    #1;
    check("rd0_drained", 64'(exp_q[0].size()), 64'd0);
    check("rd1_drained", 64'(exp_q[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_nwmr.md
Name: reg_file_nwmr

Overview:
Multi-port register file, the parametrised successor to the single-write/single-read register set.
- N write ports, M read ports, all parametrised.
- Registered read ports: 1-cycle latency with valid flag.
- Deterministic write-collision priority and a synchronous bulk clear.
- Used as the general-purpose register set and as the item/vector store in the HDC datapath, where several units write and read in the same cycle.

Parameters:
- DataWidth, 32, bits per register.
- NumRegs, 32, number of registers; need not be a power of two.
- NumWrPorts, 2, number of write ports (>=1).
- NumRdPorts, 2, number of read ports (>=1).
- NumRegsWidth, $clog2(NumRegs), derived address width; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear of all registers
- wr_en_i  in  NumWrPorts  per-port write enable
- wr_addr_i  in  NumWrPorts x NumRegsWidth  per-port write address
- wr_data_i  in  NumWrPorts x DataWidth  per-port write data
- rd_en_i  in  NumRdPorts  per-port read request
- rd_addr_i  in  NumRdPorts x NumRegsWidth  per-port read address
- rd_data_o  out  NumRdPorts x DataWidth  per-port registered read data
- rd_valid_o  out  NumRdPorts  high for 1 cycle, the cycle after an accepted rd_en_i

Behaviour:
- Clock and reset: clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset: all registers = 0, rd_data_o = 0, rd_valid_o = 0.
- Write:
  - On a clk_i edge with wr_en_i[p]=1 and wr_addr_i[p] < NumRegs, reg[wr_addr_i[p]] <= wr_data_i[p].
  - Registers not written hold their value.
- Write collision: when several enabled ports target the same address, the highest port index wins. Others are dropped silently.
- Out-of-range address (>= NumRegs):
  - Writes are ignored.
  - Reads return 0 and still assert rd_valid_o.
- Clear: clr_i=1 zeroes every register on that edge. Clear has priority over all same-cycle writes.
- Read:
  - rd_en_i[q]=1 at edge k gives rd_data_o[q] = reg[rd_addr_i[q]] and rd_valid_o[q]=1 after edge k.
  - rd_en_i[q]=0 gives rd_valid_o[q]=0; rd_data_o[q] holds its last value.
- Read/write same cycle, same address: result is governed by the optional feature below.
- Read/clear same cycle: read returns 0 when bypass is enabled, otherwise returns the old contents.
- Read ports are independent. Any number may address the same register.
- No backpressure. Throughput is 1 read per port per cycle and 1 write per port per cycle.
- Reset mid-operation: immediate return to the reset state. A pending rd_valid_o is dropped.

Optional Feature:
- Macro: REG_FILE_NWMR_BYPASS_EN.
- Defined (write-first):
  - A read at the same address as a same-cycle winning write returns that write's data.
  - A read in the same cycle as clr_i returns 0.
- Undefined (read-first): reads return pre-edge register contents. No bypass mux is built.

Decomposition:
- Package reg_file_pkg:
  - Derived width helper function: address width, with a minimum of 1.
  - Default constants: DataWidth, NumRegs, port counts.
- Sub-module reg_file_wr_sel:
  - Combinational per-register priority select over write ports.
  - Outputs: write-enable and selected data.
  - Reused for the bypass path.

Test Plan:
1. Reset, then read all addresses on every port -> all rd_data_o = 0, rd_valid_o = 1 one cycle after each request.
2. Port0 writes 0xAAAA_0001 to r5 and port1 writes 0x5555_0002 to r5 in the same cycle; read r5 next cycle -> 0x5555_0002.
3. Write 0x1234_5678 to r3 while reading r3 in the same cycle -> 0x1234_5678 with BYPASS_EN, old value 0 without; a second read gives 0x1234_5678 in both builds.
4. Fill r0..r31 with their index, then assert clr_i together with a write of 0xFFFF_FFFF to r7 -> every register reads 0, including r7.
5. NumRegs=20: write 0xDEAD_BEEF to address 25, then read addresses 25 and 4 -> address 25 returns 0 with valid; address 4 is unchanged; no aliasing.
6. Issue a read, then pulse rst_ni low before the next edge -> rd_valid_o = 0 and rd_data_o = 0; registers are zeroed.
